// File: rtl/progmem_loader.sv
// Writable program store with a byte-stream image loader.
// Serves ROM-style fetch when idle; holds the CPU while loading.
module progmem_loader #(
   parameter int ADDR_BITS = 4,
   parameter int DATA_BITS = 8,
   parameter logic [DATA_BITS-1:0] FILL_WORD = 8'h00
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [ADDR_BITS-1:0] A,
   output logic [DATA_BITS-1:0] D,
   input  logic                 load_start,
   input  logic                 load_abort,
   input  logic                 load_valid,
   input  logic [DATA_BITS-1:0] load_data,
   output logic                 load_ready,
   output logic [ADDR_BITS:0]   load_count,
   output logic                 load_done,
   output logic                 cpu_hold
);

   localparam int DEPTH = 2 ** ADDR_BITS;
   localparam logic [ADDR_BITS:0] FULL = (ADDR_BITS + 1)'(DEPTH);
   localparam logic [ADDR_BITS:0] LAST = (ADDR_BITS + 1)'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RELEASE
   } state_t;

   state_t               state;
   logic [DATA_BITS-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         load_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= FILL_WORD;
         end
      end else begin
         unique case (state)
            IDLE: begin
               if (load_start) begin
                  state      <= LOAD;
                  load_count <= '0;
               end
            end
            LOAD: begin
               // abort takes priority over a word offered in the same cycle
               if (load_abort) begin
                  state <= RELEASE;
               end else if (load_valid) begin
                  mem[load_count[ADDR_BITS-1:0]] <= load_data;
                  load_count <= load_count + 1'b1;
                  if (load_count == LAST) begin
                     state <= RELEASE;
                  end
               end
            end
            RELEASE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      load_ready = (state == LOAD);
      cpu_hold   = (state != IDLE);
      load_done  = (state == RELEASE) && (load_count == FULL);
      D          = (state == LOAD) ? FILL_WORD : mem[A];
   end

endmodule

// File: tb/tb_progmem_loader.sv
// Directed self-checking bench for progmem_loader.
// Each scenario task drives stimulus and checks its own expectations.
module tb_progmem_loader;

   logic       clk;
   logic       reset;
   logic [3:0] A;
   logic [7:0] D;
   logic       load_start;
   logic       load_abort;
   logic       load_valid;
   logic [7:0] load_data;
   logic       load_ready;
   logic [4:0] load_count;
   logic       load_done;
   logic       cpu_hold;

   int n_pass;
   int n_total;

   progmem_loader dut (
      .clk        (clk),
      .reset      (reset),
      .A          (A),
      .D          (D),
      .load_start (load_start),
      .load_abort (load_abort),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .load_count (load_count),
      .load_done  (load_done),
      .cpu_hold   (cpu_hold)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      load_start = 1'b0;
      load_abort = 1'b0;
      load_valid = 1'b0;
      load_data  = 8'h00;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // start a load and push n words without checking anything
   task automatic push_words(input int n, input logic [7:0] base,
                             input bit inc);
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < n; i++) begin
         load_valid = 1'b1;
         load_data  = inc ? base + 8'(i) : base;
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_total++;
      if (cpu_hold !== 1'b0) $display("FAIL rst_hold got %b want 0", cpu_hold);
      else n_pass++;
      n_total++;
      if (load_ready !== 1'b0) $display("FAIL rst_ready got %b want 0", load_ready);
      else n_pass++;
      n_total++;
      if (load_count !== 5'd0) $display("FAIL rst_count got %0d want 0", load_count);
      else n_pass++;
      n_total++;
      if (load_done !== 1'b0) $display("FAIL rst_done got %b want 0", load_done);
      else n_pass++;
      for (int a = 0; a < 16; a++) begin
         A = 4'(a);
         #1;
         n_total++;
         if (D !== 8'h00) $display("FAIL rst_mem[%0d] got %h want 00", a, D);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_back_to_back();
      int ready_cycles;
      int hold_cycles;
      int done_cycles;
      ready_cycles = 0;
      hold_cycles  = 0;
      done_cycles  = 0;
      A = 4'd5;
      load_start = 1'b1;
      #1;
      n_total++;
      if (cpu_hold !== 1'b0) $display("FAIL b2b_prestart_hold got %b want 0", cpu_hold);
      else n_pass++;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         load_valid = 1'b1;
         load_data  = 8'hB0 + 8'(i);
         #1;
         if (load_ready === 1'b1) ready_cycles++;
         if (cpu_hold === 1'b1) hold_cycles++;
         if (load_done === 1'b1) done_cycles++;
         n_total++;
         if (D !== 8'h00) $display("FAIL b2b_fill_D got %h want 00", D);
         else n_pass++;
         tick();
      end
      idle_inputs();
      #1;
      if (cpu_hold === 1'b1) hold_cycles++;
      n_total++;
      if (load_ready !== 1'b0) $display("FAIL b2b_rel_ready got %b want 0", load_ready);
      else n_pass++;
      n_total++;
      if (load_done !== 1'b1) $display("FAIL b2b_rel_done got %b want 1", load_done);
      else n_pass++;
      n_total++;
      if (load_count !== 5'd16) $display("FAIL b2b_rel_count got %0d want 16", load_count);
      else n_pass++;
      n_total++;
      if (D !== 8'hB5) $display("FAIL b2b_rel_D got %h want b5", D);
      else n_pass++;
      tick();
      n_total++;
      if (ready_cycles !== 16) $display("FAIL b2b_ready_cycles got %0d want 16", ready_cycles);
      else n_pass++;
      n_total++;
      if (hold_cycles !== 17) $display("FAIL b2b_hold_cycles got %0d want 17", hold_cycles);
      else n_pass++;
      n_total++;
      if (done_cycles !== 0) $display("FAIL b2b_early_done got %0d want 0", done_cycles);
      else n_pass++;
      n_total++;
      if (cpu_hold !== 1'b0 || load_done !== 1'b0)
         $display("FAIL b2b_idle hold/done got %b/%b want 0/0", cpu_hold, load_done);
      else n_pass++;
      n_total++;
      if (load_count !== 5'd16) $display("FAIL b2b_idle_count got %0d want 16", load_count);
      else n_pass++;
      n_total++;
      if (D !== 8'hB5) $display("FAIL b2b_idle_D got %h want b5", D);
      else n_pass++;
      for (int a = 0; a < 16; a++) begin
         A = 4'(a);
         #1;
         n_total++;
         if (D !== 8'hB0 + 8'(a)) $display("FAIL b2b_mem[%0d] got %h want %h", a, D, 8'hB0 + 8'(a));
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_stall();
      int idx;
      int stall;
      int cyc;
      int early_done;
      idx        = 0;
      stall      = 0;
      cyc        = 0;
      early_done = 0;
      do_reset();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      while (idx < 16 && cyc < 200) begin
         if (stall > 0) begin
            load_valid = 1'b0;
            stall--;
         end else begin
            load_valid = (cyc % 2 == 0);
         end
         load_data = 8'hB0 + 8'(idx);
         #1;
         if (load_done !== 1'b0) early_done++;
         n_total++;
         if (load_count !== 5'(idx))
            $display("FAIL stall_count got %0d want %0d", load_count, idx);
         else n_pass++;
         tick();
         if (load_valid) begin
            idx++;
            if (idx == 8) stall = 10;
         end
         cyc++;
      end
      idle_inputs();
      #1;
      n_total++;
      if (cyc >= 200) $display("FAIL stall_timeout got %0d cycles want <200", cyc);
      else n_pass++;
      n_total++;
      if (early_done !== 0) $display("FAIL stall_early_done got %0d want 0", early_done);
      else n_pass++;
      n_total++;
      if (load_done !== 1'b1 || load_count !== 5'd16)
         $display("FAIL stall_done got %b/%0d want 1/16", load_done, load_count);
      else n_pass++;
      tick();
      for (int a = 0; a < 16; a++) begin
         A = 4'(a);
         #1;
         n_total++;
         if (D !== 8'hB0 + 8'(a)) $display("FAIL stall_mem[%0d] got %h want %h", a, D, 8'hB0 + 8'(a));
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_abort();
      int done_seen;
      done_seen = 0;
      do_reset();
      push_words(16, 8'h3C, 1'b0);
      tick();
      A = 4'd7;
      load_start = 1'b1;
      load_abort = 1'b1;
      tick();
      idle_inputs();
      #1;
      n_total++;
      if (load_ready !== 1'b1) $display("FAIL abort_start_wins got %b want 1", load_ready);
      else n_pass++;
      n_total++;
      if (D !== 8'h00) $display("FAIL abort_fill_D got %h want 00", D);
      else n_pass++;
      for (int i = 0; i < 6; i++) begin
         load_valid = 1'b1;
         load_data  = 8'h71;
         #1;
         if (load_done === 1'b1) done_seen++;
         tick();
      end
      load_valid = 1'b1;
      load_data  = 8'h71;
      load_abort = 1'b1;
      tick();
      idle_inputs();
      #1;
      n_total++;
      if (cpu_hold !== 1'b1 || load_ready !== 1'b0)
         $display("FAIL abort_rel hold/ready got %b/%b want 1/0", cpu_hold, load_ready);
      else n_pass++;
      n_total++;
      if (load_done !== 1'b0 || done_seen !== 0)
         $display("FAIL abort_done got %b/%0d want 0/0", load_done, done_seen);
      else n_pass++;
      n_total++;
      if (load_count !== 5'd6) $display("FAIL abort_count got %0d want 6", load_count);
      else n_pass++;
      tick();
      n_total++;
      if (cpu_hold !== 1'b0 || load_done !== 1'b0)
         $display("FAIL abort_idle hold/done got %b/%b want 0/0", cpu_hold, load_done);
      else n_pass++;
      for (int a = 0; a < 16; a++) begin
         A = 4'(a);
         #1;
         n_total++;
         if (D !== ((a < 6) ? 8'h71 : 8'h3C))
            $display("FAIL abort_mem[%0d] got %h want %h", a, D, (a < 6) ? 8'h71 : 8'h3C);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_abort_last();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < 15; i++) begin
         load_valid = 1'b1;
         load_data  = 8'h5A;
         load_start = (i == 3);
         tick();
      end
      load_start = 1'b0;
      load_valid = 1'b1;
      load_data  = 8'hEE;
      load_abort = 1'b1;
      tick();
      idle_inputs();
      #1;
      n_total++;
      if (load_count !== 5'd15) $display("FAIL last_count got %0d want 15", load_count);
      else n_pass++;
      n_total++;
      if (load_done !== 1'b0) $display("FAIL last_done got %b want 0", load_done);
      else n_pass++;
      tick();
      for (int a = 0; a < 16; a++) begin
         A = 4'(a);
         #1;
         n_total++;
         if (D !== ((a < 15) ? 8'h5A : 8'h3C))
            $display("FAIL last_mem[%0d] got %h want %h", a, D, (a < 15) ? 8'h5A : 8'h3C);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_reset_midload();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         load_valid = 1'b1;
         load_data  = 8'hC0 + 8'(i);
         tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      idle_inputs();
      #1;
      n_total++;
      if (cpu_hold !== 1'b0 || load_ready !== 1'b0)
         $display("FAIL mid_rst hold/ready got %b/%b want 0/0", cpu_hold, load_ready);
      else n_pass++;
      n_total++;
      if (load_count !== 5'd0 || load_done !== 1'b0)
         $display("FAIL mid_rst count/done got %0d/%b want 0/0", load_count, load_done);
      else n_pass++;
      for (int a = 0; a < 16; a++) begin
         A = 4'(a);
         #1;
         n_total++;
         if (D !== 8'h00) $display("FAIL mid_rst_mem[%0d] got %h want 00", a, D);
         else n_pass++;
         tick();
      end
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      A       = 4'd0;
      reset   = 1'b1;
      idle_inputs();
      test_reset();
      test_back_to_back();
      test_stall();
      test_abort();
      test_abort_last();
      test_reset_midload();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
